// File: rtl/pe_operand_loader.sv
// Ping-pong operand loader: packs (a,b) element beats into flat A/B vectors for the PE array.
// Latency 1 cycle from closing beat to vec_valid; in_ready drops only when both banks hold vectors.
module pe_operand_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ARRAY_SIZE = 128,
  parameter int LEN_WIDTH  = $clog2(ARRAY_SIZE + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_WIDTH-1:0]            in_a,
  input  logic [DATA_WIDTH-1:0]            in_b,
  input  logic                             in_last,
  output logic                             vec_valid,
  input  logic                             vec_ready,
  output logic [DATA_WIDTH*ARRAY_SIZE-1:0] A,
  output logic [DATA_WIDTH*ARRAY_SIZE-1:0] B,
  output logic [LEN_WIDTH-1:0]             vec_len
);

  localparam int IDX_W = $clog2(ARRAY_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARRAY_SIZE - 1);

  logic [1:0]                full_q, full_d;
  logic                      wr_bank_q, wr_bank_d;
  logic                      rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]          wr_idx_q, wr_idx_d;
  logic [1:0][LEN_WIDTH-1:0] len_q, len_d;

  logic [DATA_WIDTH-1:0] a_mem_q [2][ARRAY_SIZE];
  logic [DATA_WIDTH-1:0] b_mem_q [2][ARRAY_SIZE];

  logic accept;
  logic rel;
  logic closing;
  logic [LEN_WIDTH-1:0] cur_len;

  assign in_ready  = !full_q[wr_bank_q];
  assign vec_valid = full_q[rd_bank_q];
  assign accept    = in_valid && in_ready;
  assign rel       = vec_valid && vec_ready;
  assign closing   = in_last || (wr_idx_q == LAST_IDX);

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    len_d     = len_q;
    if (flush) begin
      full_d    = '0;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      wr_idx_d  = '0;
      len_d     = '0;
    end else begin
      // Release and accept always target different banks, so both can apply.
      if (rel) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
      if (accept) begin
        if (closing) begin
          full_d[wr_bank_q] = 1'b1;
          len_d[wr_bank_q]  = LEN_WIDTH'(wr_idx_q) + LEN_WIDTH'(1);
          wr_idx_d          = '0;
          wr_bank_d         = !wr_bank_q;
        end else begin
          wr_idx_d = wr_idx_q + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      len_q     <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      len_q     <= len_d;
    end
  end

  // Lane storage is never cleared; stale lanes are hidden by the length mask below.
  always_ff @(posedge clk) begin
    if (accept && !flush) begin
      a_mem_q[wr_bank_q][wr_idx_q] <= in_a;
      b_mem_q[wr_bank_q][wr_idx_q] <= in_b;
    end
  end

  assign cur_len = vec_valid ? len_q[rd_bank_q] : '0;
  assign vec_len = cur_len;

  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
    localparam logic [LEN_WIDTH-1:0] LANE = LEN_WIDTH'(g);
    logic lane_on;
    assign lane_on = LANE < cur_len;
    assign A[(ARRAY_SIZE-g)*DATA_WIDTH-1 -: DATA_WIDTH] = lane_on ? a_mem_q[rd_bank_q][g] : '0;
    assign B[(ARRAY_SIZE-g)*DATA_WIDTH-1 -: DATA_WIDTH] = lane_on ? b_mem_q[rd_bank_q][g] : '0;
  end

endmodule

// File: tb/tb_pe_operand_loader.sv
// Bench for pe_operand_loader: directed phases plus random traffic against a queue-based vector model.
module tb_pe_operand_loader;
  localparam int W  = 16;
  localparam int N  = 128;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, in_last, vec_valid, vec_ready;
  logic [W-1:0]  in_a, in_b;
  logic [N*W-1:0] A, B;
  logic [LW-1:0] vec_len;

  int errors = 0;
  int checks = 0;

  // Model: completed vectors awaiting release (oldest first) plus the one being filled.
  logic [N*W-1:0] pa[$];
  logic [N*W-1:0] pb[$];
  int             plen[$];
  logic [N*W-1:0] cur_a, cur_b;
  int             cur_n;

  pe_operand_loader #(.DATA_WIDTH(W), .ARRAY_SIZE(N), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .A(A), .B(B), .vec_len(vec_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    int bad;
    bad = -1;
    checks++;
    assert (obs === exp) else begin
      errors++;
      for (int i = N - 1; i >= 0; i--)
        if (obs[(N-i)*W-1 -: W] !== exp[(N-i)*W-1 -: W]) bad = i;
      if (bad < 0) bad = 0;
      $error("FAIL %s lane=%0d observed=%0h expected=%0h", tag, bad,
             obs[(N-bad)*W-1 -: W], exp[(N-bad)*W-1 -: W]);
    end
  endtask

  task automatic model_clear();
    pa.delete(); pb.delete(); plen.delete();
    cur_a = '0; cur_b = '0; cur_n = 0;
  endtask

  task automatic check_outputs();
    logic [N*W-1:0] ea, eb;
    int el;
    ea = '0; eb = '0; el = 0;
    if (pa.size() > 0) begin
      ea = pa[0]; eb = pb[0]; el = plen[0];
    end
    chk("in_ready", in_ready, pa.size() < 2);
    chk("vec_valid", vec_valid, pa.size() > 0);
    chk("vec_len", vec_len, el);
    chkw("A", A, ea);
    chkw("B", B, eb);
  endtask

  // Called at a falling edge with inputs already driven; checks, then advances one cycle.
  task automatic tick();
    logic acc, rel, fl, last;
    logic [W-1:0] a, b;
    check_outputs();
    acc  = in_valid && (pa.size() < 2);
    rel  = (pa.size() > 0) && vec_ready;
    fl   = flush;
    last = in_last;
    a    = in_a;
    b    = in_b;
    @(posedge clk);
    if (fl) model_clear();
    else begin
      if (rel) begin
        void'(pa.pop_front()); void'(pb.pop_front()); void'(plen.pop_front());
      end
      if (acc) begin
        cur_a[(N-cur_n)*W-1 -: W] = a;
        cur_b[(N-cur_n)*W-1 -: W] = b;
        cur_n++;
        if (cur_n == N || last) begin
          pa.push_back(cur_a); pb.push_back(cur_b); plen.push_back(cur_n);
          cur_a = '0; cur_b = '0; cur_n = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic last, input logic rdy);
    in_valid = v; in_a = a; in_b = b; in_last = last; vec_ready = rdy;
  endtask

  initial begin
    int lows;
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    model_clear();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Full vector a=i, b=2i at full rate.
    for (int i = 0; i < N; i++) begin
      drive(1'b1, W'(i), W'(2 * i), 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    chk("full_vld", vec_valid, 1);
    chk("full_a_lsb", A[W-1:0], 127);
    chk("full_a_msb", A[N*W-1 -: W], 0);
    chk("full_b_lsb", B[W-1:0], 254);
    chk("full_len", vec_len, 128);
    tick();
    tick();

    // Short vector closed by in_last on beat 4.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, W'(i + 1), W'($urandom), i == 4, 1'b1);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    chk("short_len", vec_len, 5);
    chk("short_lane4", A[(N-4)*W-1 -: W], 5);
    chk("short_lane5", A[(N-5)*W-1 -: W], 0);
    tick();
    tick();

    // Backpressure: both banks fill, then a single-cycle release.
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0);
      tick();
    end
    chk("bp_in_ready", in_ready, 0);
    chk("bp_vld", vec_valid, 1);
    drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b1);
    tick();
    chk("bp_ready_after_rel", in_ready, 1);
    for (int k = 0; k < 140; k++) begin
      drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      tick();
    end

    // Back-to-back vectors with an always-ready consumer.
    lows = 0;
    for (int k = 0; k < 4 * N; k++) begin
      drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b1);
      if (!in_ready) lows++;
      tick();
    end
    chk("b2b_in_ready_low", lows, 0);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    tick();

    // Asynchronous reset mid-fill with a vector pending.
    for (int k = 0; k < N + 60; k++) begin
      drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0);
      tick();
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", vec_valid, 0);
    chk("arst_rdy", in_ready, 1);
    chk("arst_len", vec_len, 0);
    chkw("arst_A", A, '0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    chk("arst_refill_len", vec_len, 128);
    tick();
    tick();

    // Flush coinciding with a release while the other bank is half filled.
    for (int k = 0; k < N + 64; k++) begin
      drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    chk("flush_vld", vec_valid, 0);
    chk("flush_len", vec_len, 0);
    chk("flush_rdy", in_ready, 1);
    for (int k = 0; k < 20; k++) tick();

    // Random traffic with occasional flush.
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 3) != 0, W'($urandom), W'($urandom),
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 199) == 0);
      tick();
    end
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
